// File: rtl/down_timer.sv
// down_timer: loadable down-counter with one-shot and auto-reload modes.
//
// Ports:
//   Clock  - rising-edge clock for all state
//   Resetn - asynchronous active-low reset
//   Enable - count qualifier; only counting edges need it
//   Load   - writes D into the reload register and into Q, returns to IDLE
//   D      - load value
//   Start  - begins a countdown from the reload register (ignored while running)
//   Mode   - 0 = one-shot, 1 = auto-reload
//   Q      - current count, registered
//   Tc     - single-cycle terminal-count pulse, registered
//   Busy   - high while counting
//   Done   - high once a one-shot countdown has finished
module down_timer #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Enable,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   input  logic             Start,
   input  logic             Mode,
   output logic [WIDTH-1:0] Q,
   output logic             Tc,
   output logic             Busy,
   output logic             Done
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] rld_q, rld_d;
   logic             tc_q, tc_d;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      rld_d   = rld_q;
      tc_d    = 1'b0;   // Tc is a pulse: it drops on every edge that does not re-raise it

      if (Load) begin
         rld_d   = D;
         q_d     = D;
         state_d = StIdle;
      end else if (Start && (state_q != StRun)) begin
         if (rld_q != '0) begin
            q_d     = rld_q;
            state_d = StRun;
         end else begin
            // A zero reload finishes immediately rather than wrapping.
            q_d     = '0;
            state_d = StDone;
            tc_d    = 1'b1;
         end
      end else if ((state_q == StRun) && Enable) begin
         if (q_q == '0) begin
            // Only reached in auto-reload: the zero cycle completes the Rld+1 period.
            if (Mode) begin
               q_d = rld_q;
            end else begin
               state_d = StDone;
            end
         end else if (q_q == WIDTH'(1)) begin
            q_d  = '0;
            tc_d = 1'b1;
            if (!Mode) begin
               state_d = StDone;
            end
         end else begin
            q_d = q_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= StIdle;
         q_q     <= '0;
         rld_q   <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         rld_q   <= rld_d;
         tc_q    <= tc_d;
      end
   end

   assign Q    = q_q;
   assign Tc   = tc_q;
   assign Busy = (state_q == StRun);
   assign Done = (state_q == StDone);

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed stimulus for down_timer, checked every cycle against a
// rule-level model plus hand-computed literal expectations.
module tb_down_timer;

   localparam int W = 3;

   logic         Clock  = 1'b0;
   logic         Resetn = 1'b1;
   logic         Enable = 1'b0;
   logic         Load   = 1'b0;
   logic [W-1:0] D      = '0;
   logic         Start  = 1'b0;
   logic         Mode   = 1'b0;
   logic [W-1:0] Q;
   logic         Tc;
   logic         Busy;
   logic         Done;

   down_timer #(.WIDTH(W)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Enable (Enable),
      .Load   (Load),
      .D      (D),
      .Start  (Start),
      .Mode   (Mode),
      .Q      (Q),
      .Tc     (Tc),
      .Busy   (Busy),
      .Done   (Done)
   );

   always #5 Clock = ~Clock;

   int n_cmp = 0;
   int n_bad = 0;
   bit fin   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: mode names, not encodings.
   localparam int MIdle = 0;
   localparam int MRun  = 1;
   localparam int MDone = 2;

   typedef struct {
      int st;
      int q;
      int rld;
      int tc;
   } mdl_t;

   mdl_t m = '{MIdle, 0, 0, 0};

   function automatic mdl_t step(input mdl_t c, input bit ld, input bit st, input bit en,
                                 input bit md, input int d);
      mdl_t n;
      n    = c;
      n.tc = 0;
      if (ld) begin
         n.rld = d;
         n.q   = d;
         n.st  = MIdle;
      end else if (st && c.st != MRun) begin
         if (c.rld == 0) begin
            n.q  = 0;
            n.st = MDone;
            n.tc = 1;
         end else begin
            n.q  = c.rld;
            n.st = MRun;
         end
      end else if (c.st == MRun && en) begin
         if (c.q == 0) begin
            if (md) n.q = c.rld;
            else    n.st = MDone;
         end else begin
            n.q = c.q - 1;
            if (n.q == 0) begin
               n.tc = 1;
               if (!md) n.st = MDone;
            end
         end
      end
      return n;
   endfunction

   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) m <= '{MIdle, 0, 0, 0};
      else         m <= step(m, Load, Start, Enable, Mode, int'(D));
   end

   always @(negedge Clock) begin
      if (!fin) begin
         chk("model_q",    int'(Q),    m.q);
         chk("model_tc",   int'(Tc),   m.tc);
         chk("model_busy", int'(Busy), int'(m.st == MRun));
         chk("model_done", int'(Done), int'(m.st == MDone));
      end
   end

   // Apply one edge's inputs; returns 2 time units after that edge.
   task automatic cyc(input bit ld, input bit st, input bit en, input bit md, input int d);
      Load   = ld;
      Start  = st;
      Enable = en;
      Mode   = md;
      D      = W'(d);
      @(posedge Clock);
      #2;
   endtask

   task automatic expect4(input string tag, input int q, input int tc, input int bsy,
                          input int dn);
      chk({tag, "_q"},    int'(Q),    q);
      chk({tag, "_tc"},   int'(Tc),   tc);
      chk({tag, "_busy"}, int'(Busy), bsy);
      chk({tag, "_done"}, int'(Done), dn);
   endtask

   initial begin
      #1 Resetn = 1'b0;
      @(posedge Clock);
      #2;
      expect4("reset", 0, 0, 0, 0);
      Resetn = 1'b1;

      // One-shot from 5.
      cyc(1, 0, 0, 0, 5);
      expect4("os_load", 5, 0, 0, 0);
      cyc(0, 1, 1, 0, 0);
      expect4("os_start", 5, 0, 1, 0);
      for (int k = 1; k <= 5; k++) begin
         cyc(0, 0, 1, 0, 0);
         expect4($sformatf("os_k%0d", k), 5 - k, int'(k == 5), int'(k != 5), int'(k == 5));
      end
      cyc(0, 0, 1, 0, 0);
      expect4("os_hold", 0, 0, 0, 1);

      // Auto-reload, Rld=3: period 4.
      cyc(1, 0, 0, 1, 3);
      cyc(0, 1, 1, 1, 0);
      expect4("ar_start", 3, 0, 1, 0);
      for (int k = 1; k <= 12; k++) begin
         int e;
         e = (3 - k + 12) % 4;
         cyc(0, 0, 1, 1, 0);
         expect4($sformatf("ar_k%0d", k), e, int'(e == 0), 1, 0);
      end

      // Enable gating from Q=4.
      cyc(1, 0, 0, 0, 4);
      cyc(0, 1, 0, 0, 0);
      expect4("en_start", 4, 0, 1, 0);
      cyc(0, 0, 1, 0, 0);
      expect4("en_1", 3, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      expect4("en_0a", 3, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      expect4("en_0b", 3, 0, 1, 0);
      cyc(0, 0, 1, 0, 0);
      expect4("en_1b", 2, 0, 1, 0);

      // Zero reload, then Load while running.
      cyc(1, 0, 0, 0, 0);
      expect4("z_load", 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      expect4("z_start", 0, 1, 0, 1);
      cyc(0, 0, 0, 0, 0);
      expect4("z_after", 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 4);
      cyc(0, 1, 1, 0, 0);
      expect4("lr_run", 4, 0, 1, 0);
      cyc(1, 0, 1, 0, 7);
      expect4("lr_load", 7, 0, 0, 0);

      // Start ignored in RUN; Mode dropped at the reload edge.
      cyc(1, 0, 0, 1, 2);
      cyc(0, 1, 1, 1, 0);
      expect4("md_start", 2, 0, 1, 0);
      cyc(0, 1, 1, 1, 0);
      expect4("md_restart_ignored", 1, 0, 1, 0);
      cyc(0, 0, 1, 1, 0);
      expect4("md_tc", 0, 1, 1, 0);
      cyc(0, 0, 1, 0, 0);
      expect4("md_stop", 0, 0, 0, 1);

      // Asynchronous reset mid-run.
      cyc(1, 0, 0, 0, 3);
      cyc(0, 1, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      expect4("rst_pre", 2, 0, 1, 0);
      Enable = 1'b0;
      Resetn = 1'b0;
      #1;
      expect4("rst_async", 0, 0, 0, 0);
      #1 Resetn = 1'b1;
      cyc(0, 0, 1, 0, 0);
      expect4("rst_idle", 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      expect4("rst_start", 0, 1, 0, 1);

      // Load beats Start.
      cyc(1, 0, 0, 0, 2);
      cyc(1, 1, 0, 0, 6);
      expect4("pri_load", 6, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      expect4("pri_start", 6, 0, 1, 0);
      cyc(0, 0, 1, 0, 0);
      expect4("pri_count", 5, 0, 1, 0);

      @(negedge Clock);
      fin = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1, "timeout");
   end

endmodule
